// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-register bridge.
package uart_bridge_pkg;

  // Bridge control FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARGS    = 3'd1,
    ST_DISCARD = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RDWAIT  = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Reply selector: acknowledge, error, or read data
  typedef enum logic [1:0] {
    RSP_K    = 2'd0,
    RSP_E    = 2'd1,
    RSP_DATA = 2'd2
  } resp_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_K    = 8'h4B;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_W_LC = 8'h77;

  // Reply buffer depth: one hex character per data nibble plus CR LF
  function automatic int unsigned reply_depth(input int unsigned data_w);
    return data_w / 4 + 2;
  endfunction

endpackage

// File: rtl/hex_ascii_codec.sv
// Combinational hex codec: ASCII to nibble (any case) and nibble to uppercase ASCII.
module hex_ascii_codec (
  input  logic [7:0] ascii_in,
  input  logic [3:0] nibble_in,
  output logic       hex_valid_c,
  output logic [3:0] nibble_c,
  output logic [7:0] ascii_c
);

  // Decode one ASCII character into a nibble
  always_comb begin
    hex_valid_c = 1'b0;
    nibble_c    = 4'h0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      hex_valid_c = 1'b1;
      nibble_c    = 4'(ascii_in - 8'h30);
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h46) begin
      hex_valid_c = 1'b1;
      nibble_c    = 4'(ascii_in - 8'h37);
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      hex_valid_c = 1'b1;
      nibble_c    = 4'(ascii_in - 8'h57);
    end
  end

  // Encode one nibble as an uppercase hex character
  always_comb begin
    if (nibble_in < 4'd10) ascii_c = 8'h30 + {4'h0, nibble_in};
    else                   ascii_c = 8'h37 + {4'h0, nibble_in};
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// ASCII command line to register bus bridge between UART RX and TX FIFOs.
// Build option UART_REG_BRIDGE_ECHO_EN: echo every popped byte to TX in the same cycle.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_rden,
  output logic [7:0]        tx_data,
  output logic              tx_wren,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int unsigned NA       = ADDR_W / 4;
  localparam int unsigned ND       = DATA_W / 4;
  localparam int unsigned ARG_W    = ADDR_W + DATA_W;
  localparam int unsigned NARG     = NA + ND;
  localparam int unsigned CNT_W    = $clog2(NARG + 1);
  localparam int unsigned RB_DEPTH = reply_depth(DATA_W);
  localparam int unsigned IDX_W    = $clog2(RB_DEPTH + 1);

  state_e             state_q, state_d;
  logic [7:0]         byte_q;
  logic               byte_vld_q;
  logic               is_rd_q;
  logic [ARG_W-1:0]   arg_q;
  logic [CNT_W-1:0]   cnt_q;
  resp_e              resp_kind_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               is_term_c, is_cmd_c, cmd_rd_c;
  logic               hex_valid_c;
  logic [3:0]         hex_nib_c;
  logic [3:0]         enc_nib_c;
  logic [7:0]         enc_ascii_c;
  resp_e              reply_kind_c;
  logic [IDX_W-1:0]   reply_idx_c;
  logic [IDX_W-1:0]   reply_last_c;
  logic [DATA_W-1:0]  rdata_src_c;
  logic [7:0]         reply_byte_c;
  logic [CNT_W-1:0]   cnt_exp_c;
  logic               start_args_c, shift_arg_c, exec_c;
  logic               resp_load_c, push_reply_c, rx_ok_c;
  resp_e              resp_kind_d;

  hex_ascii_codec u_codec (
    .ascii_in    (byte_q),
    .nibble_in   (enc_nib_c),
    .hex_valid_c (hex_valid_c),
    .nibble_c    (hex_nib_c),
    .ascii_c     (enc_ascii_c)
  );

  // Classify the registered RX byte
  always_comb begin
    is_term_c = (byte_q == ASCII_CR) || (byte_q == ASCII_LF);
    cmd_rd_c  = (byte_q == ASCII_R_UC) || (byte_q == ASCII_R_LC);
    is_cmd_c  = cmd_rd_c || (byte_q == ASCII_W_UC) || (byte_q == ASCII_W_LC);
    cnt_exp_c = is_rd_q ? CNT_W'(NA) : CNT_W'(NARG);
  end

  // Select the current reply byte; RDWAIT sends the first data character straight from reg_rdata
  always_comb begin
    reply_kind_c = (state_q == ST_RDWAIT) ? RSP_DATA : resp_kind_q;
    reply_idx_c  = (state_q == ST_RDWAIT) ? '0 : idx_q;
    rdata_src_c  = (state_q == ST_RDWAIT) ? reg_rdata : rdata_q;
    enc_nib_c    = 4'h0;
    for (int i = 0; i < int'(ND); i++) begin
      if (reply_idx_c == IDX_W'(i)) enc_nib_c = rdata_src_c[4*(int'(ND)-1-i) +: 4];
    end
    if (reply_kind_c == RSP_DATA) begin
      reply_last_c = IDX_W'(RB_DEPTH - 1);
      if (reply_idx_c < IDX_W'(ND))       reply_byte_c = enc_ascii_c;
      else if (reply_idx_c == IDX_W'(ND)) reply_byte_c = ASCII_CR;
      else                                reply_byte_c = ASCII_LF;
    end else begin
      reply_last_c = IDX_W'(2);
      if (reply_idx_c == '0)               reply_byte_c = (reply_kind_c == RSP_K) ? ASCII_K : ASCII_E;
      else if (reply_idx_c == IDX_W'(1))   reply_byte_c = ASCII_CR;
      else                                 reply_byte_c = ASCII_LF;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, FIFO handshakes and datapath controls
  always_comb begin
    state_d      = state_q;
    start_args_c = 1'b0;
    shift_arg_c  = 1'b0;
    exec_c       = 1'b0;
    resp_load_c  = 1'b0;
    resp_kind_d  = RSP_E;
    push_reply_c = 1'b0;
    rx_ok_c      = 1'b0;
    rx_rden      = 1'b0;
    tx_wren      = 1'b0;
    tx_data      = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_vld_q && !is_term_c) begin
          if (is_cmd_c) begin
            state_d      = ST_ARGS;
            start_args_c = 1'b1;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_ARGS: begin
        if (byte_vld_q) begin
          if (is_term_c) begin
            if (cnt_q == cnt_exp_c) begin
              state_d = ST_EXEC;
              exec_c  = 1'b1;
            end else begin
              state_d     = ST_RESP;
              resp_load_c = 1'b1;
              resp_kind_d = RSP_E;
            end
          end else if (hex_valid_c && (cnt_q < CNT_W'(NARG))) begin
            shift_arg_c = 1'b1;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (byte_vld_q && is_term_c) begin
          state_d     = ST_RESP;
          resp_load_c = 1'b1;
          resp_kind_d = RSP_E;
        end
      end
      ST_EXEC: begin
        if (is_rd_q) begin
          state_d = ST_RDWAIT;
        end else begin
          state_d     = ST_RESP;
          resp_load_c = 1'b1;
          resp_kind_d = RSP_K;
        end
      end
      ST_RDWAIT: begin
        state_d      = ST_RESP;
        resp_load_c  = 1'b1;
        resp_kind_d  = RSP_DATA;
        push_reply_c = !tx_full;
      end
      ST_RESP: begin
        if (!tx_full) begin
          push_reply_c = 1'b1;
          if (idx_q == reply_last_c) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop only while the line is still being collected and the FSM stays in a collecting state
    rx_ok_c = ((state_q == ST_IDLE) || (state_q == ST_ARGS) || (state_q == ST_DISCARD)) &&
              ((state_d == ST_IDLE) || (state_d == ST_ARGS) || (state_d == ST_DISCARD));
`ifdef UART_REG_BRIDGE_ECHO_EN
    rx_rden = !rst && !rx_empty && !tx_full && rx_ok_c;
`else
    rx_rden = !rst && !rx_empty && rx_ok_c;
`endif

    if (push_reply_c && !rst) begin
      tx_wren = 1'b1;
      tx_data = reply_byte_c;
    end
`ifdef UART_REG_BRIDGE_ECHO_EN
    // Echo and reply pushes never coincide: pops and replies happen in disjoint states
    if (rx_rden) begin
      tx_wren = 1'b1;
      tx_data = rx_data;
    end
`endif
  end

  // Byte register, argument shifter, reply tracking and register bus outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      byte_q      <= 8'h00;
      byte_vld_q  <= 1'b0;
      is_rd_q     <= 1'b0;
      arg_q       <= '0;
      cnt_q       <= '0;
      resp_kind_q <= RSP_E;
      idx_q       <= '0;
      rdata_q     <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
    end else begin
      byte_vld_q <= rx_rden;
      if (rx_rden) byte_q <= rx_data;

      if (start_args_c) begin
        is_rd_q <= cmd_rd_c;
        arg_q   <= '0;
        cnt_q   <= '0;
      end else if (shift_arg_c) begin
        arg_q <= {arg_q[ARG_W-5:0], hex_nib_c};
        cnt_q <= cnt_q + CNT_W'(1);
      end

      reg_we <= exec_c && !is_rd_q;
      reg_re <= exec_c && is_rd_q;
      if (exec_c) begin
        if (is_rd_q) begin
          reg_addr <= arg_q[ADDR_W-1:0];
        end else begin
          reg_addr  <= arg_q[ARG_W-1:DATA_W];
          reg_wdata <= arg_q[DATA_W-1:0];
        end
      end

      if (resp_load_c) begin
        resp_kind_q <= resp_kind_d;
        idx_q       <= push_reply_c ? IDX_W'(1) : '0;
      end else if (push_reply_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (state_q == ST_RDWAIT) rdata_q <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge with FWFT RX FIFO and 256x8 register array models.
module tb_uart_reg_bridge;

`ifdef UART_REG_BRIDGE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } reg_ev_t;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rden;
  logic [7:0] tx_data;
  logic       tx_wren;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  logic [7:0] rx_mem [256];
  logic [7:0] rx_wr, rx_rd;
  logic [7:0] regs [256];

  logic [7:0] tx_exp [$];
  reg_ev_t    reg_exp [$];
  int         total, bad, tx_seen;

  always #5 CLK = ~CLK;

  uart_reg_bridge #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_rden   (rx_rden),
    .tx_data   (tx_data),
    .tx_wren   (tx_wren),
    .tx_full   (tx_full),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_data  = rx_mem[rx_rd];

  // RX FIFO pop pointer and register array with 1-cycle read latency
  always @(posedge CLK) begin
    if (rx_rden) rx_rd <= rx_rd + 8'd1;
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      reg_rdata <= 8'h00;
    end else begin
      if (reg_we) regs[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= regs[reg_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every TX push and register strobe against the scoreboard queues
  always @(negedge CLK) begin
    if (!rst) begin
      if (tx_wren) begin
        tx_seen++;
        chk("tx_wren_while_full", 32'(tx_full), 32'd0);
        if (tx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %02h want none", tx_data);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(tx_exp.pop_front()));
        end
      end
      if (ECHO && rx_rden) chk("pop_while_full", 32'(tx_full), 32'd0);
      if (reg_we || reg_re) begin
        chk("reg_we_re_exclusive", 32'(reg_we & reg_re), 32'd0);
        if (reg_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL reg_unexpected: got we=%0d re=%0d addr=%02h want none", reg_we, reg_re, reg_addr);
        end else begin
          reg_ev_t e;
          e = reg_exp.pop_front();
          chk("reg_is_write", 32'(reg_we), 32'(e.we));
          chk("reg_addr", 32'(reg_addr), 32'(e.addr));
          if (e.we) chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
        end
      end
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_mem[rx_wr] = s[i];
      rx_wr = rx_wr + 8'd1;
    end
  endtask

  task automatic exp_tx(input string s);
    for (int i = 0; i < s.len(); i++) tx_exp.push_back(s[i]);
  endtask

  task automatic exp_echo(input string s);
    if (ECHO) exp_tx(s);
  endtask

  task automatic exp_reg(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    reg_ev_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    reg_exp.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || reg_exp.size() != 0 || rx_wr != rx_rd) && n < 400) begin
      @(posedge CLK);
      n++;
    end
    repeat (10) @(posedge CLK);
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_timeout: got tx_left=%0d reg_left=%0d want 0", name, tx_exp.size(), reg_exp.size());
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_rx_rden"}, 32'(rx_rden), 32'd0);
    chk({name, "_tx"}, {23'd0, tx_wren, tx_data}, 32'd0);
    chk({name, "_reg_bus"}, {16'd0, reg_addr, reg_wdata}, 32'd0);
    chk({name, "_strobes"}, {30'd0, reg_we, reg_re}, 32'd0);
  endtask

  initial begin
    int seen_before;
    total = 0; bad = 0; tx_seen = 0;
    rx_wr = 8'd0; rx_rd = 8'd0;
    rst = 1'b1; tx_full = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_outputs_zero("reset");
    @(posedge CLK); #1 rst = 1'b0;

    // 1: write 0x3C <= 0xA5
    exp_echo("W3CA5\015"); exp_tx("K\015\n"); exp_reg(1'b1, 8'h3C, 8'hA5);
    @(posedge CLK); #1 send("W3CA5\015");
    drain("t1");

    // 2: lowercase read back, trailing LF ignored
    exp_echo("r3c\015"); exp_tx("A5\015\n"); exp_echo("\n"); exp_reg(1'b0, 8'h3C, 8'h00);
    @(posedge CLK); #1 send("r3c\015\n");
    drain("t2");

    // 3: three malformed lines
    exp_echo("W3CG5\n"); exp_tx("E\015\n");
    exp_echo("X\n");     exp_tx("E\015\n");
    exp_echo("R3\n");    exp_tx("E\015\n");
    @(posedge CLK); #1 send("W3CG5\nX\nR3\n");
    drain("t3");

    // 4: read while TX FIFO is full for 20 cycles
    exp_echo("R00\015"); exp_tx("00\015\n");
    if (!ECHO) exp_reg(1'b0, 8'h00, 8'h00);
    @(posedge CLK); #1 tx_full = 1'b1; send("R00\015");
    seen_before = tx_seen;
    repeat (20) @(posedge CLK);
    chk("t4_no_push_while_full", 32'(tx_seen), 32'(seen_before));
    if (ECHO) begin
      chk("t4_no_pop_while_full", 32'(rx_rd), 32'(rx_wr - 8'd4));
      exp_reg(1'b0, 8'h00, 8'h00);
    end
    #1 tx_full = 1'b0;
    drain("t4");

    // 5: reset mid-line drops the partial command
    exp_echo("W12");
    @(posedge CLK); #1 send("W12");
    drain("t5a");
    @(posedge CLK); #1 rst = 1'b1;
    @(posedge CLK); #1 rst = 1'b0;
    @(negedge CLK);
    chk_outputs_zero("t5_after_rst");
    exp_echo("R12\015"); exp_tx("00\015\n"); exp_reg(1'b0, 8'h12, 8'h00);
    @(posedge CLK); #1 send("R12\015");
    drain("t5b");

    // 6: write with a toggling full flag, then read back
    exp_echo("W0102\015"); exp_tx("K\015\n"); exp_reg(1'b1, 8'h01, 8'h02);
    exp_echo("R01\015");   exp_tx("02\015\n"); exp_reg(1'b0, 8'h01, 8'h00);
    @(posedge CLK); #1 send("W0102\015R01\015");
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1 tx_full = (i % 3 == 0);
    end
    tx_full = 1'b0;
    drain("t6");

    chk("final_tx_queue", 32'(tx_exp.size()), 32'd0);
    chk("final_reg_queue", 32'(reg_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
